// File: rtl/wb_mem_slave.sv
// Word-addressed Wishbone-style memory slave with a programmable wait-state counter.
// Define WB_MEM_BOUNDS_EN to flag out-of-range accesses with Wb_err instead of aliasing.
module wb_mem_slave #(
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter int              DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              WAIT_STATES = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] Wb_addr,
    input  logic              Wb_cs,
    input  logic              Wb_we,
    input  logic [DATA_W-1:0] Wb_wdata,
    output logic [DATA_W-1:0] Wb_rdata,
    output logic              Wb_ack,
    output logic              Wb_err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  idx_q;
    logic              oob_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_r;
    logic              ack_r;
    logic              err_r;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] off_bus;
    logic [ADDR_W-3:0] word_bus;
    logic [IDX_W-1:0]  idx_bus;
    logic              oob_bus;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_oob;
    logic [DATA_W-1:0] rd_val;
    logic              unused_bits;

    // Offset is modular at ADDR_W bits, so addresses below BASE_ADDR wrap high.
    assign off_bus  = Wb_addr - BASE_ADDR;
    assign word_bus = off_bus[ADDR_W-1:2];
    assign idx_bus  = word_bus[IDX_W-1:0];

`ifdef WB_MEM_BOUNDS_EN
    assign oob_bus     = (word_bus >= (ADDR_W-2)'(DEPTH));
    assign unused_bits = ^off_bus[1:0];
`else
    assign oob_bus     = 1'b0;
    assign unused_bits = ^{off_bus[1:0], word_bus[ADDR_W-3:IDX_W]};
`endif

    // Read data is sampled on the edge that enters ACK; from IDLE that is the capture edge.
    always_comb begin
        rd_idx = (state == IDLE) ? idx_bus : idx_q;
        rd_oob = (state == IDLE) ? oob_bus : oob_q;
        rd_val = rd_oob ? DATA_W'(32'hDEAD_BEEF) : mem[rd_idx];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            oob_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_r <= '0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= '0;
            case (state)
                IDLE: begin
                    if (Wb_cs) begin
                        idx_q   <= idx_bus;
                        oob_q   <= oob_bus;
                        we_q    <= Wb_we;
                        wdata_q <= Wb_wdata;
                        cnt     <= 4'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            state   <= ACK;
                            ack_r   <= 1'b1;
                            err_r   <= oob_bus;
                            rdata_r <= Wb_we ? '0 : rd_val;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (!Wb_cs) begin
                        state <= IDLE;
                    end else if (cnt == 4'd1) begin
                        state   <= ACK;
                        ack_r   <= 1'b1;
                        err_r   <= oob_q;
                        rdata_r <= we_q ? '0 : rd_val;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Commit on the edge leaving ACK; an async reset forces IDLE first, so no write slips out.
    always_ff @(posedge Clk) begin
        if (state == ACK && we_q && !oob_q)
            mem[idx_q] <= wdata_q;
    end

    assign Wb_rdata = rdata_r;
    assign Wb_ack   = ack_r;
    assign Wb_err   = err_r;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Scoreboard bench for wb_mem_slave: three instances with WAIT_STATES = 1, 0 and 3.
module tb_wb_mem_slave;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst_n;
    logic        cs    [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ack   [3];
    logic        err   [3];

    wb_mem_slave #(.WAIT_STATES(1)) u_ws1 (
        .Clk(Clk), .Rst_n(Rst_n), .Wb_addr(addr[0]), .Wb_cs(cs[0]), .Wb_we(we[0]),
        .Wb_wdata(wdata[0]), .Wb_rdata(rdata[0]), .Wb_ack(ack[0]), .Wb_err(err[0]));
    wb_mem_slave #(.WAIT_STATES(0)) u_ws0 (
        .Clk(Clk), .Rst_n(Rst_n), .Wb_addr(addr[1]), .Wb_cs(cs[1]), .Wb_we(we[1]),
        .Wb_wdata(wdata[1]), .Wb_rdata(rdata[1]), .Wb_ack(ack[1]), .Wb_err(err[1]));
    wb_mem_slave #(.WAIT_STATES(3)) u_ws3 (
        .Clk(Clk), .Rst_n(Rst_n), .Wb_addr(addr[2]), .Wb_cs(cs[2]), .Wb_we(we[2]),
        .Wb_wdata(wdata[2]), .Wb_rdata(rdata[2]), .Wb_ack(ack[2]), .Wb_err(err[2]));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        rd;
        int          cyc;
    } exp_t;

    exp_t q [3][$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   ack_cnt [3];

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic int ws_of(int u);
        case (u)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every Ack pops one expectation and checks cycle, error flag and read data.
    always @(negedge Clk) begin
        exp_t e;
        for (int u = 0; u < 3; u++) begin
            if (ack[u] === 1'b1) begin
                ack_cnt[u]++;
                if (q[u].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack u%0d: got ack at cycle %0d expected none", u, cyc);
                end else begin
                    e = q[u].pop_front();
                    chk($sformatf("ack_cycle_u%0d", u), 32'(cyc), 32'(e.cyc));
                    chk($sformatf("err_u%0d", u), {31'd0, err[u]}, {31'd0, e.err});
                    if (e.rd) chk($sformatf("rdata_u%0d", u), rdata[u], e.rdata);
                end
            end
        end
    end

    // Issue one request at a negedge; the Ack is expected WS+1 negedges later.
    task automatic req(int u, bit w, logic [31:0] a, logic [31:0] d,
                       logic [31:0] exp_rd, bit exp_err, bit hold);
        int n;
        cs[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d;
        q[u].push_back('{exp_rd, exp_err, !w, cyc + 1 + ws_of(u)});
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (ack[u] !== 1'b1 && n < 40);
        if (ack[u] !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout_u%0d: got no ack expected ack within 40 cycles", u);
            cs[u] = 1'b0;
            if (q[u].size() > 0) q[u].delete(q[u].size() - 1);
            return;
        end
        if (!hold) cs[u] = 1'b0;
        @(negedge Clk);
        chk($sformatf("ack_width_u%0d", u), {31'd0, ack[u]}, 32'd0);
    endtask

    task automatic chk_outputs_zero(string tag);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("%s_ack_u%0d", tag, u), {31'd0, ack[u]}, 32'd0);
            chk($sformatf("%s_err_u%0d", tag, u), {31'd0, err[u]}, 32'd0);
            chk($sformatf("%s_rdata_u%0d", tag, u), rdata[u], 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        Rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            cs[u] = 1'b0; we[u] = 1'b0; addr[u] = '0; wdata[u] = '0; ack_cnt[u] = 0;
        end
        repeat (3) @(negedge Clk);
        chk_outputs_zero("reset");
        Rst_n = 1'b1;
        @(negedge Clk);

        // Write then read with one wait state.
        req(0, 1, 32'h10, 32'h1234_5678, 32'h0, 0, 0);
        req(0, 0, 32'h10, 32'h0, 32'h1234_5678, 0, 0);

        // Zero wait states: preload, then three reads with cs held high (Acks two cycles apart).
        req(1, 1, 32'h0, 32'h1111_0000, 32'h0, 0, 0);
        req(1, 1, 32'h4, 32'h2222_0001, 32'h0, 0, 0);
        req(1, 1, 32'h8, 32'h3333_0002, 32'h0, 0, 0);
        req(1, 0, 32'h0, 32'h0, 32'h1111_0000, 0, 1);
        req(1, 0, 32'h4, 32'h0, 32'h2222_0001, 0, 1);
        req(1, 0, 32'h8, 32'h0, 32'h3333_0002, 0, 0);

        // Abort during WAIT with three wait states: no Ack, RAM unchanged.
        req(2, 1, 32'h40, 32'h5555_AAAA, 32'h0, 0, 0);
        base = ack_cnt[2];
        cs[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'hDEAD_0000;
        @(negedge Clk);
        cs[2] = 1'b0;
        repeat (8) @(negedge Clk);
        chk("abort_no_ack", 32'(ack_cnt[2]), 32'(base));
        req(2, 0, 32'h40, 32'h0, 32'h5555_AAAA, 0, 0);

        // Reset mid-WAIT on a write: no Ack, old data survives, outputs held at zero.
        req(2, 1, 32'h20, 32'h7777_0020, 32'h0, 0, 0);
        base = ack_cnt[2];
        cs[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'hFFFF_0000;
        @(negedge Clk);
        Rst_n = 1'b0;
        cs[2] = 1'b0;
        @(negedge Clk);
        chk_outputs_zero("midreset");
        Rst_n = 1'b1;
        repeat (6) @(negedge Clk);
        chk("reset_no_ack", 32'(ack_cnt[2]), 32'(base));
        req(2, 0, 32'h20, 32'h0, 32'h7777_0020, 0, 0);

        // Out-of-range handling at word index DEPTH.
        req(0, 1, 32'h0, 32'hCAFE_0000, 32'h0, 0, 0);
`ifdef WB_MEM_BOUNDS_EN
        req(0, 0, 32'h1000, 32'h0, 32'hDEAD_BEEF, 1, 0);
        req(0, 1, 32'h1000, 32'hA5A5_A5A5, 32'h0, 1, 0);
        req(0, 0, 32'h0, 32'h0, 32'hCAFE_0000, 0, 0);
`else
        req(0, 1, 32'h1000, 32'hA5A5_A5A5, 32'h0, 0, 0);
        req(0, 0, 32'h0, 32'h0, 32'hA5A5_A5A5, 0, 0);
        req(0, 0, 32'h1000, 32'h0, 32'hA5A5_A5A5, 0, 0);
`endif

        repeat (4) @(negedge Clk);
        for (int u = 0; u < 3; u++)
            chk($sformatf("queue_drained_u%0d", u), 32'(q[u].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
